// File: rtl/jt6295_cmd_tx_if.sv
// Request channel into the JT6295 command sequencer: valid/ready handshake
// carrying a play/stop request, channel mask, phrase number and attenuation.
interface jt6295_cmd_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_play;
  logic [3:0] req_ch;
  logic [6:0] req_phrase;
  logic [3:0] req_att;

  modport master (
    output req_valid, req_play, req_ch, req_phrase, req_att,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_play, req_ch, req_phrase, req_att,
    output req_ready
  );
endinterface

// File: rtl/jt6295_cmd_tx.sv
// JT6295 command write sequencer: queues play/stop requests in a small FIFO and
// replays them as wrn/dout byte writes with programmable low, gap and start-gap timing.
module jt6295_cmd_tx #(
  parameter int AW        = 2,
  parameter int WR_LOW    = 4,
  parameter int WR_GAP    = 4,
  parameter int START_GAP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cen,
  jt6295_cmd_tx_if.slave   rq,
  output logic             o_wrn,
  output logic [7:0]       o_dout,
  output logic             o_idle,
  output logic [AW:0]      o_level
);

  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = (START_GAP > WR_LOW)
                         ? ((START_GAP > WR_GAP) ? START_GAP : WR_GAP)
                         : ((WR_LOW > WR_GAP) ? WR_LOW : WR_GAP);
  localparam int CW    = (MAXC <= 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] C_LOW   = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] C_GAP   = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] C_START = CW'(START_GAP - 1);
  localparam logic [AW:0]   L_FULL  = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_byte2;
  logic          r_pend;
  logic          r_b2;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_head;
  logic          w_play;
  logic [3:0]    w_ch;
  logic [6:0]    w_phrase;
  logic [3:0]    w_att;

  function automatic logic [7:0] start_byte1(input logic [6:0] phrase);
    return {1'b1, phrase};
  endfunction

  function automatic logic [7:0] start_byte2(input logic [3:0] ch, input logic [3:0] att);
    return {ch, att};
  endfunction

  function automatic logic [7:0] stop_byte(input logic [3:0] ch);
    return {1'b0, ch, 3'b000};
  endfunction

  assign w_full       = (r_level == L_FULL);
  assign rq.req_ready = !w_full;
  assign w_push       = rq.req_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && (r_level != '0);
  assign w_head       = r_mem[r_rptr];
  assign {w_play, w_ch, w_phrase, w_att} = w_head;

  assign o_idle  = (r_level == '0) && (r_state == S_IDLE);
  assign o_level = r_level;

  // FIFO storage: entry = {play, ch, phrase, att}
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {rq.req_play, rq.req_ch, rq.req_phrase, rq.req_att};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Write FSM: dout only moves on the edge that drops wrn, so it is stable while wrn is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_b2    <= 1'b0;
      r_byte2 <= '0;
      o_wrn   <= 1'b1;
      o_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            o_wrn   <= 1'b0;
            r_cnt   <= C_LOW;
            r_b2    <= 1'b0;
            r_pend  <= w_play;
            r_byte2 <= start_byte2(w_ch, w_att);
            o_dout  <= w_play ? start_byte1(w_phrase) : stop_byte(w_ch);
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (i_cen) begin
            if (r_cnt == '0) begin
              o_wrn   <= 1'b1;
              r_cnt   <= r_b2 ? C_START : C_GAP;
              r_state <= S_HIGH;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (i_cen) begin
            if (r_cnt == '0) begin
              if (r_pend) begin
                o_dout  <= r_byte2;
                o_wrn   <= 1'b0;
                r_cnt   <= C_LOW;
                r_pend  <= 1'b0;
                r_b2    <= 1'b1;
                r_state <= S_LOW;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_cmd_tx.sv
// Directed bench for jt6295_cmd_tx: records every wrn pulse (byte, low width,
// preceding high width, dout stability) and compares against hand-computed values.
module tb_jt6295_cmd_tx;

  logic       clk;
  logic       rst;
  logic       i_cen;
  logic       o_wrn;
  logic [7:0] o_dout;
  logic       o_idle;
  logic [2:0] o_level;

  int n_vec = 0;
  int n_err = 0;

  jt6295_cmd_tx_if rq ();

  jt6295_cmd_tx #(.AW(2), .WR_LOW(4), .WR_GAP(4), .START_GAP(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_cen   (i_cen),
    .rq      (rq),
    .o_wrn   (o_wrn),
    .o_dout  (o_dout),
    .o_idle  (o_idle),
    .o_level (o_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse recorder, sampled on the inactive edge
  logic [7:0] byte_q [$];
  int         len_q  [$];
  int         gap_q  [$];
  bit         chg_q  [$];
  logic       prev_wrn = 1'b1;
  int         low_cnt  = 0;
  int         high_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  bit         dchg     = 1'b0;

  always @(negedge clk) begin
    if (o_wrn === 1'b0) begin
      if (prev_wrn) begin
        gap_q.push_back(high_cnt);
        cur_byte = o_dout;
        low_cnt  = 1;
        dchg     = 1'b0;
      end else begin
        low_cnt++;
        if (o_dout !== cur_byte) dchg = 1'b1;
      end
    end else begin
      if (!prev_wrn) begin
        byte_q.push_back(cur_byte);
        len_q.push_back(low_cnt);
        chg_q.push_back(dchg);
        high_cnt = 1;
      end else begin
        high_cnt++;
      end
    end
    prev_wrn = o_wrn;
  end

  function automatic logic [7:0] qb(input int i);
    return (i < byte_q.size()) ? byte_q[i] : 8'hxx;
  endfunction
  function automatic int ql(input int i);
    return (i < len_q.size()) ? len_q[i] : -1;
  endfunction
  function automatic int qg(input int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction
  function automatic int qc(input int i);
    return (i < chg_q.size()) ? int'(chg_q[i]) : -1;
  endfunction

  task automatic set_req(input logic v, input logic p, input logic [3:0] ch,
                         input logic [6:0] ph, input logic [3:0] at);
    rq.req_valid  = v;
    rq.req_play   = p;
    rq.req_ch     = ch;
    rq.req_phrase = ph;
    rq.req_att    = at;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (o_idle === 1'b1 && o_wrn === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    i_cen = 1'b1;
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    repeat (2) @(negedge clk);
    n_vec++; if (o_wrn !== 1'b1) begin n_err++; $display("FAIL reset_wrn: got %b want 1", o_wrn); end
    n_vec++; if (o_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", o_dout); end
    n_vec++; if (rq.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rq.req_ready); end
    n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", o_idle); end
    n_vec++; if (o_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", o_level); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop();
    int base;
    int k;
    bit ok;
    base = gap_q.size();
    set_req(1'b1, 1'b0, 4'b0101, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    n_vec++; if (o_wrn !== 1'b1) begin n_err++; $display("FAIL stop_no_bypass_wrn: got %b want 1", o_wrn); end
    n_vec++; if (o_level !== 3'd1) begin n_err++; $display("FAIL stop_level_after_push: got %0d want 1", o_level); end
    @(negedge clk);
    n_vec++; if (o_wrn !== 1'b0) begin n_err++; $display("FAIL stop_wrn_low_E1: got %b want 0", o_wrn); end
    n_vec++; if (o_dout !== 8'h28) begin n_err++; $display("FAIL stop_dout: got %h want 28", o_dout); end
    n_vec++; if (o_level !== 3'd0) begin n_err++; $display("FAIL stop_level_after_pop: got %0d want 0", o_level); end
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_idle === 1'b1) break;
    end
    n_vec++; if (k !== 8) begin n_err++; $display("FAIL stop_idle_cycles: got %0d want 8", k); end
    n_vec++; if (qb(base) !== 8'h28) begin n_err++; $display("FAIL stop_byte: got %h want 28", qb(base)); end
    n_vec++; if (ql(base) !== 4) begin n_err++; $display("FAIL stop_low_width: got %0d want 4", ql(base)); end
    n_vec++; if (qc(base) !== 0) begin n_err++; $display("FAIL stop_dout_stable: got %0d want 0", qc(base)); end
    // Stop with an empty mask goes out unchanged
    set_req(1'b1, 1'b0, 4'b0000, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    wait_idle(60, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL stop0_timeout: got %b want 1", ok); end
    n_vec++; if (qb(base+1) !== 8'h00) begin n_err++; $display("FAIL stop0_byte: got %h want 00", qb(base+1)); end
    n_vec++; if (gap_q.size() - base !== 2) begin n_err++; $display("FAIL stop_pulse_count: got %0d want 2", gap_q.size() - base); end
  endtask

  task automatic test_start();
    int base;
    bit ok;
    base = gap_q.size();
    set_req(1'b1, 1'b1, 4'b0010, 7'h15, 4'h3);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    wait_idle(100, ok);
    repeat (2) @(negedge clk);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL start_timeout: got %b want 1", ok); end
    n_vec++; if (gap_q.size() - base !== 2) begin n_err++; $display("FAIL start_pulse_count: got %0d want 2", gap_q.size() - base); end
    n_vec++; if (qb(base) !== 8'h95) begin n_err++; $display("FAIL start_byte1: got %h want 95", qb(base)); end
    n_vec++; if (qb(base+1) !== 8'h23) begin n_err++; $display("FAIL start_byte2: got %h want 23", qb(base+1)); end
    n_vec++; if (ql(base) !== 4) begin n_err++; $display("FAIL start_low1: got %0d want 4", ql(base)); end
    n_vec++; if (qg(base+1) !== 4) begin n_err++; $display("FAIL start_gap12: got %0d want 4", qg(base+1)); end
    n_vec++; if (ql(base+1) !== 4) begin n_err++; $display("FAIL start_low2: got %0d want 4", ql(base+1)); end
    n_vec++; if (qc(base) + qc(base+1) !== 0) begin n_err++; $display("FAIL start_dout_stable: got %0d want 0", qc(base) + qc(base+1)); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ph [5];
    logic [3:0] ch [5];
    logic [3:0] at [5];
    logic [7:0] eb [11];
    int         eg [11];
    int base, acc, cyc, acc_full, lvl_full;
    bit rdy, saw_full, ok;
    ph = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
    ch = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    at = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
    eb = '{8'h78, 8'h81, 8'h10, 8'h82, 8'h21, 8'h83, 8'h42, 8'h84, 8'h83, 8'h85, 8'h1F};
    eg = '{0, 5, 4, 17, 4, 17, 4, 17, 4, 17, 4};
    base = gap_q.size();
    // A stop keeps the FSM busy so the starts pile up in the FIFO
    set_req(1'b1, 1'b0, 4'b1111, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    @(negedge clk);
    acc = 0; cyc = 0; saw_full = 1'b0; acc_full = -1; lvl_full = -1;
    while (acc < 5 && cyc < 200) begin
      set_req(1'b1, 1'b1, ch[acc], ph[acc], at[acc]);
      rdy = rq.req_ready;
      if (!rdy && !saw_full) begin
        saw_full = 1'b1;
        acc_full = acc;
        lvl_full = int'(o_level);
      end
      @(negedge clk);
      if (rdy) acc++;
      cyc++;
    end
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    n_vec++; if (acc_full !== 4) begin n_err++; $display("FAIL fill_accepted_before_full: got %0d want 4", acc_full); end
    n_vec++; if (lvl_full !== 4) begin n_err++; $display("FAIL fill_level_full: got %0d want 4", lvl_full); end
    n_vec++; if (acc !== 5) begin n_err++; $display("FAIL fill_all_accepted: got %0d want 5", acc); end
    wait_idle(400, ok);
    repeat (2) @(negedge clk);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL fill_timeout: got %b want 1", ok); end
    n_vec++; if (gap_q.size() - base !== 11) begin n_err++; $display("FAIL fill_pulse_count: got %0d want 11", gap_q.size() - base); end
    for (int i = 0; i < 11; i++) begin
      n_vec++; if (qb(base+i) !== eb[i]) begin n_err++; $display("FAIL fill_byte[%0d]: got %h want %h", i, qb(base+i), eb[i]); end
      n_vec++; if (ql(base+i) !== 4) begin n_err++; $display("FAIL fill_low[%0d]: got %0d want 4", i, ql(base+i)); end
      if (i > 0) begin
        n_vec++; if (qg(base+i) !== eg[i]) begin n_err++; $display("FAIL fill_gap[%0d]: got %0d want %0d", i, qg(base+i), eg[i]); end
      end
    end
  endtask

  task automatic test_cen_quarter();
    int base;
    base = gap_q.size();
    set_req(1'b1, 1'b1, 4'b0000, 7'h7F, 4'hA);
    i_cen = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    i_cen = 1'b1;
    for (int k = 2; k <= 130; k++) begin
      @(negedge clk);
      i_cen = ((k % 4) == 1);
    end
    i_cen = 1'b1;
    @(negedge clk);
    n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL cen_idle_end: got %b want 1", o_idle); end
    n_vec++; if (gap_q.size() - base !== 2) begin n_err++; $display("FAIL cen_pulse_count: got %0d want 2", gap_q.size() - base); end
    n_vec++; if (qb(base) !== 8'hFF) begin n_err++; $display("FAIL cen_byte1: got %h want ff", qb(base)); end
    n_vec++; if (qb(base+1) !== 8'h0A) begin n_err++; $display("FAIL cen_byte2: got %h want 0a", qb(base+1)); end
    n_vec++; if (ql(base) !== 16) begin n_err++; $display("FAIL cen_low1: got %0d want 16", ql(base)); end
    n_vec++; if (qg(base+1) !== 16) begin n_err++; $display("FAIL cen_gap: got %0d want 16", qg(base+1)); end
    n_vec++; if (ql(base+1) !== 16) begin n_err++; $display("FAIL cen_low2: got %0d want 16", ql(base+1)); end
    n_vec++; if (qc(base) + qc(base+1) !== 0) begin n_err++; $display("FAIL cen_dout_stable: got %0d want 0", qc(base) + qc(base+1)); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = gap_q.size();
    set_req(1'b1, 1'b1, 4'b0100, 7'h11, 4'h5);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'b0011, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    n_vec++; if (o_wrn !== 1'b0) begin n_err++; $display("FAIL rstmid_wrn_low: got %b want 0", o_wrn); end
    n_vec++; if (o_level !== 3'd1) begin n_err++; $display("FAIL rstmid_level_before: got %0d want 1", o_level); end
    rst = 1'b1;
    #1;
    n_vec++; if (o_wrn !== 1'b1) begin n_err++; $display("FAIL rstmid_wrn_async: got %b want 1", o_wrn); end
    n_vec++; if (o_level !== 3'd0) begin n_err++; $display("FAIL rstmid_level_async: got %0d want 0", o_level); end
    n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: got %b want 1", o_idle); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++; if (gap_q.size() - base !== 1) begin n_err++; $display("FAIL rstmid_no_byte2: got %0d pulses want 1", gap_q.size() - base); end
    n_vec++; if (qb(base) !== 8'h91) begin n_err++; $display("FAIL rstmid_byte1: got %h want 91", qb(base)); end
    n_vec++; if (o_wrn !== 1'b1) begin n_err++; $display("FAIL rstmid_wrn_after: got %b want 1", o_wrn); end
  endtask

  task automatic test_push_pop();
    int base;
    bit ok;
    base = gap_q.size();
    set_req(1'b1, 1'b0, 4'b0001, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'b0010, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    repeat (7) @(negedge clk);
    n_vec++; if (o_level !== 3'd1) begin n_err++; $display("FAIL pp_level_before: got %0d want 1", o_level); end
    set_req(1'b1, 1'b0, 4'b1000, 7'h00, 4'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 7'h00, 4'h0);
    n_vec++; if (o_level !== 3'd1) begin n_err++; $display("FAIL pp_level_same_cycle: got %0d want 1", o_level); end
    n_vec++; if (o_wrn !== 1'b0) begin n_err++; $display("FAIL pp_wrn_pop: got %b want 0", o_wrn); end
    n_vec++; if (o_dout !== 8'h10) begin n_err++; $display("FAIL pp_dout_pop: got %h want 10", o_dout); end
    wait_idle(60, ok);
    repeat (2) @(negedge clk);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL pp_timeout: got %b want 1", ok); end
    n_vec++; if (gap_q.size() - base !== 3) begin n_err++; $display("FAIL pp_pulse_count: got %0d want 3", gap_q.size() - base); end
    n_vec++; if (qb(base) !== 8'h08) begin n_err++; $display("FAIL pp_byte0: got %h want 08", qb(base)); end
    n_vec++; if (qb(base+1) !== 8'h10) begin n_err++; $display("FAIL pp_byte1: got %h want 10", qb(base+1)); end
    n_vec++; if (qb(base+2) !== 8'h40) begin n_err++; $display("FAIL pp_byte2: got %h want 40", qb(base+2)); end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_start();
    test_back_to_back();
    test_cen_quarter();
    test_reset_mid();
    test_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
